// File: rtl/frame_word_assembler.sv
// Beat-to-word deframer: header-qualified, MSB-first assembly of BEATS beats with trailer check.
// Optional macro FRAME_ERR_CNT_EN adds a saturating 8-bit err_cnt output.
//
// state      | meaning
// ST_IDLE    | waiting for a beat whose header field matches HDR_VAL
// ST_COLLECT | accumulating the remaining beats of a frame, watching the idle gap
module frame_word_assembler #(
  parameter int               IN_W    = 8,
  parameter int               BEATS   = 4,
  parameter int               HDR_W   = 4,
  parameter logic [HDR_W-1:0] HDR_VAL = 4'hA,
  parameter int               TRL_W   = 16,
  parameter logic [TRL_W-1:0] TRL_VAL = 16'hBEAF,
  parameter int               TIMEOUT = 15
) (
  input  logic                  div_8_clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  input  logic [IN_W-1:0]       data_in,
  output logic                  out_valid,
  output logic [IN_W*BEATS-1:0] data_out,
  output logic                  frame_err,
  output logic                  busy
`ifdef FRAME_ERR_CNT_EN
  ,output logic [7:0]           err_cnt
`endif
);

  localparam int OUT_W = IN_W * BEATS;
  localparam int SR_W  = OUT_W - IN_W;
  localparam int BC_W  = $clog2(BEATS);
  localparam int GAP_W = $clog2(TIMEOUT + 1);

  localparam logic [0:0] ST_IDLE    = 1'b0;
  localparam logic [0:0] ST_COLLECT = 1'b1;

  localparam logic [BC_W-1:0]  LAST_BEAT = BC_W'(BEATS - 1);
  localparam logic [GAP_W-1:0] GAP_LAST  = GAP_W'(TIMEOUT - 1);

  logic [0:0]       state;
  logic [SR_W-1:0]  shift_reg;
  logic [BC_W-1:0]  beat_cnt;
  logic [GAP_W-1:0] gap_cnt;

  logic [OUT_W-1:0] candidate;
  logic             hdr_hit;
  logic             last_beat;
  logic             trl_ok;
  logic             word_good;
  logic             word_bad;
  logic             gap_abort;

  // shift_reg only holds the beats already taken; the current beat completes the word
  assign candidate = {shift_reg, data_in};
  assign hdr_hit   = in_valid && (data_in[IN_W-1 -: HDR_W] == HDR_VAL);
  assign last_beat = (state == ST_COLLECT) && in_valid && (beat_cnt == LAST_BEAT);
  assign trl_ok    = (candidate[TRL_W-1:0] == TRL_VAL);
  assign word_good = last_beat && trl_ok;
  assign word_bad  = last_beat && !trl_ok;
  assign gap_abort = (state == ST_COLLECT) && !in_valid && (gap_cnt == GAP_LAST);
  assign busy      = (state == ST_COLLECT);

  always_ff @(posedge div_8_clk) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      shift_reg <= '0;
      beat_cnt  <= '0;
      gap_cnt   <= '0;
      data_out  <= '0;
      out_valid <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      out_valid <= word_good;
      frame_err <= word_bad || gap_abort;
      if (word_good)
        data_out <= candidate;

      case (state)
        ST_IDLE: begin
          if (hdr_hit) begin
            shift_reg <= SR_W'(data_in);
            beat_cnt  <= BC_W'(1);
            gap_cnt   <= '0;
            state     <= ST_COLLECT;
          end
        end
        default: begin
          if (in_valid) begin
            gap_cnt   <= '0;
            shift_reg <= candidate[SR_W-1:0];
            if (last_beat) begin
              beat_cnt <= '0;
              state    <= ST_IDLE;
            end else begin
              beat_cnt <= beat_cnt + 1'b1;
            end
          end else if (gap_abort) begin
            gap_cnt  <= '0;
            beat_cnt <= '0;
            state    <= ST_IDLE;
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
          end
        end
      endcase
    end
  end

`ifdef FRAME_ERR_CNT_EN
  always_ff @(posedge div_8_clk) begin
    if (!rst_n)
      err_cnt <= 8'h00;
    else if ((word_bad || gap_abort) && (err_cnt != 8'hFF))
      err_cnt <= err_cnt + 8'd1;
  end
`endif

endmodule

// File: doc/frame_word_assembler.md
Name: frame_word_assembler

Overview:
Parametrised beat-to-word deframer for the div_8_clk domain.
- Accepts qualified IN_W-bit beats.
- Detects a frame start by the header field in the top bits of the first beat.
- Assembles BEATS beats MSB-first into one OUT_W word.
- Checks the trailer field in the low bits and publishes good words with a one-cycle valid strobe.
- Adds over the single-width assembler: input qualifier, valid strobe, gap timeout, error reporting and back-to-back frames.
- Sits between the serial-to-parallel front end and the word-level self-test checker.

Parameters:
IN_W, 8, beat width in bits
BEATS, 4, beats per frame; minimum 2; OUT_W = IN_W*BEATS
HDR_W, 4, header field width, taken from data_in[IN_W-1 -: HDR_W] of the first beat; HDR_W <= IN_W
HDR_VAL, 4'hA, header match value
TRL_W, 16, trailer field width, taken from word[TRL_W-1:0]; TRL_W <= OUT_W-IN_W
TRL_VAL, 16'hBEAF, trailer match value
TIMEOUT, 15, number of consecutive idle cycles mid-frame before abort; minimum 1

Ports:
div_8_clk  in  1  clock; all logic on its rising edge
rst_n  in  1  synchronous, active-low reset
in_valid  in  1  data_in qualifier; a beat is accepted only when in_valid=1
data_in  in  IN_W  beat data
out_valid  out  1  one-cycle strobe; data_out holds a new good word
data_out  out  IN_W*BEATS  last good assembled word; holds value between frames
frame_err  out  1  one-cycle strobe on trailer mismatch or timeout abort
busy  out  1  high while in COLLECT
err_cnt  out  8  saturating error count; present only with FRAME_ERR_CNT_EN

Behaviour:
- Reset (rst_n=0 at an edge):
  - state=IDLE; shift register, beat_cnt and gap_cnt cleared.
  - data_out=0, out_valid=0, frame_err=0, busy=0, err_cnt=0.
  - Reset mid-frame discards the partial frame silently, with no frame_err.
- State IDLE:
  - Header beat (in_valid=1 and header field == HDR_VAL): load the beat into the shift register, set beat_cnt=1, set gap_cnt=0, go to COLLECT.
  - Any other beat, or in_valid=0: ignored; no strobe.
- State COLLECT, beat accepted (in_valid=1):
  - Shift left by IN_W; the new beat enters the LSBs; beat_cnt++; gap_cnt=0.
  - A header-valued beat mid-frame is ordinary data; no resync.
- Last beat accepted (beat_cnt == BEATS-1 and in_valid=1):
  - Candidate word = {shift_reg[OUT_W-IN_W-1:0], data_in}, evaluated combinationally.
  - Trailer match: at the same edge, data_out <= candidate and out_valid=1 for the next cycle.
  - Trailer mismatch: frame_err=1 for the next cycle; data_out is unchanged.
  - In both cases, return to IDLE.
  - Latency: out_valid or frame_err is high in the cycle immediately after the edge that samples the last beat.
- Back-to-back frames: a header beat in the cycle right after the last beat is accepted with no dead cycle, so the frame period is exactly BEATS cycles.
- Timeout (COLLECT, in_valid=0):
  - gap_cnt++ each idle cycle.
  - If in_valid=0 while gap_cnt == TIMEOUT-1, abort at that edge: return to IDLE and set frame_err=1 for the next cycle.
  - An abort therefore follows exactly TIMEOUT consecutive idle cycles.
  - gap_cnt width is clog2(TIMEOUT+1).
- Strobes: out_valid and frame_err are never high together; each is high for exactly one cycle per event.
- busy = (state == COLLECT), registered with the state.
- beat_cnt width is clog2(BEATS).

Optional Feature:
Macro: FRAME_ERR_CNT_EN
- Defined:
  - err_cnt port is present.
  - err_cnt increments by 1 on every frame_err event (mismatch or timeout) and saturates at 8'hFF.
  - Cleared only by reset.
- Undefined:
  - err_cnt port and its register are absent.
  - frame_err strobe behaviour is unchanged.

Test Plan:
1. Defaults; beats A1,23,BE,AF on consecutive cycles with in_valid=1 -> next cycle out_valid=1 for 1 cycle, data_out=32'hA123BEAF, frame_err=0, busy falls.
2. Beats A5,00,12,34 -> frame_err=1 for 1 cycle, data_out unchanged, err_cnt 0->1 with FRAME_ERR_CNT_EN.
3. In IDLE: beats 55,B0,0A with in_valid=1, then A0 with in_valid=0 -> no out_valid, no frame_err, busy stays 0.
4. Beat A0, then 15 cycles of in_valid=0 -> frame_err pulse after the 15th idle cycle, state IDLE; then A7,77,BE,AF -> data_out=32'hA777BEAF. Also 14 idle cycles then 11,BE,AF -> no abort; data_out=32'hA011BEAF.
5. Frames A1,23,BE,AF and A4,56,BE,AF with no gap -> two out_valid pulses exactly 4 cycles apart, data_out=A123BEAF then A456BEAF. Repeat 300 bad frames -> err_cnt saturates at 8'hFF.
6. rst_n=0 for 1 cycle after beats A1,23 -> no strobe, data_out=0, err_cnt=0; following frame AB,CD,BE,AF -> data_out=32'hABCDBEAF.
